flag_branch_unit: RTL

Condition-flag register and branch resolver sitting directly downstream of the ALU's 64-bit zero detector and adder. It captures N/Z/C/V when a flag-setting instruction executes, and evaluates B.cond, CBZ, CBNZ and B decisions against either the stored flags or the current ALU zero result. The registered decision feeds PC-select logic one cycle later.

---
 rtl/alu_flags_pkg.sv | 28 ++
 rtl/flag_branch_unit_cond_eval.sv | 39 +++
 rtl/flag_branch_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/alu_flags_pkg.sv
// Shared types and constants for the condition-flag register and branch resolver.
package alu_flags_pkg;

  typedef enum logic [1:0] {
    BR_COND   = 2'b00,
    BR_CBZ    = 2'b01,
    BR_CBNZ   = 2'b10,
    BR_UNCOND = 2'b11
  } br_type_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } out_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational B.cond evaluator: condition code against {N,Z,C,V}.
module cond_eval
  import alu_flags_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  logic gt;

  always_comb begin
    n    = flags[FLAG_N];
    z    = flags[FLAG_Z];
    c    = flags[FLAG_C];
    v    = flags[FLAG_V];
    gt   = !z && (n == v);
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_HS: pass = c;
      COND_LO: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !(c && !z);
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = gt;
      COND_LE: pass = !gt;
      default: pass = 1'b1;  // AL and NV both always pass
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// NZCV flag register with same-cycle bypass and a registered branch decision
// for the PC-select stage.
module flag_branch_unit
  import alu_flags_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       alu_carry,
  input  logic       alu_ovf,
  input  logic       set_flags,
  input  logic       br_valid,
  input  logic [1:0] br_type,
  input  logic [3:0] cond,
  input  logic       stall,
  input  logic       flush,
  output logic [3:0] flags_q,
  output logic       taken_valid,
  output logic       taken
);

  logic [3:0] alu_flags;
  logic [3:0] flags_d;
  logic [3:0] eff_flags;
  logic       cond_pass;
  logic       decision;
  out_state_e state_q, state_d;
  logic       taken_q, taken_d;

  always_comb begin
    alu_flags = {alu_neg, alu_zero, alu_carry, alu_ovf};
    flags_d   = flags_q;
    if (set_flags && !stall) flags_d = alu_flags;
    // A flag-setting op in the same cycle as the branch must be seen by it.
    eff_flags = set_flags ? alu_flags : flags_q;
  end

  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (eff_flags),
    .pass  (cond_pass)
  );

  always_comb begin
    decision = 1'b1;
    case (br_type_e'(br_type))
      BR_COND:   decision = cond_pass;
      BR_CBZ:    decision = alu_zero;
      BR_CBNZ:   decision = !alu_zero;
      default:   decision = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    if (!stall) begin
      if (br_valid && !flush) begin
        state_d = ST_PRESENT;
        taken_d = decision;
      end else begin
        state_d = ST_IDLE;
        taken_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
      state_q <= ST_IDLE;
      taken_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

  assign taken_valid = (state_q == ST_PRESENT);
  assign taken       = taken_q;

endmodule
